// File: rtl/cassette_recorder_if.sv
// SDRAM write port of the cassette recorder: one-byte write request held until the
// memory side accepts it.
`timescale 1ns/1ps
interface cassette_recorder_if;
  logic [20:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_wr;
  logic        sdram_available;
  logic        sdram_ready;

  modport master (
    output sdram_addr, sdram_data, sdram_wr,
    input  sdram_available, sdram_ready
  );

  modport slave (
    input  sdram_addr, sdram_data, sdram_wr,
    output sdram_available, sdram_ready
  );
endinterface

// File: rtl/cassette_recorder.sv
// SVI-328 tape record path: FSK half-period decoder, CAS header insertion, byte FIFO
// and SDRAM writer that builds a .CAS image in the cassette area.
`timescale 1ns/1ps
module cassette_recorder #(
  parameter logic [15:0] HALF_MIN   = 16'd1900,
  parameter logic [15:0] HALF_THR   = 16'd6700,
  parameter logic [15:0] HALF_MAX   = 16'd11500,
  parameter logic [9:0]  LEADER_MIN = 10'd256,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                record,
  input  logic                rewind,
  input  logic                tap_i,
  cassette_recorder_if.master bus,
  output logic [20:0]         length,
  output logic [2:0]          status
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LEADER, HDR, SYNC, DATA} state_t;
  state_t state, next_state;

  logic [2:0]    tap_sync;
  logic [15:0]   hcnt;
  logic          have_half, half_long;
  logic [9:0]    lcnt;
  logic [2:0]    hidx, bcnt;
  logic          one_half;
  logic [6:0]    shreg;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr, fill;
  logic          full, empty, push, pop, err, drop;
  logic [7:0]    push_data;
  logic          wr_req, addr_full, overflow, decode_error;
  logic [20:0]   wr_addr;
  logic [7:0]    wr_data;
  logic          tap_edge, half_ok, is_long, lost, short_cyc, long_cyc, mixed, bit_done;

  function automatic logic [7:0] hdr_byte(input logic [2:0] i);
    case (i)
      3'd0:    hdr_byte = 8'h1F;
      3'd1:    hdr_byte = 8'hA6;
      3'd2:    hdr_byte = 8'hDE;
      3'd3:    hdr_byte = 8'hBA;
      3'd4:    hdr_byte = 8'hCC;
      3'd5:    hdr_byte = 8'h13;
      3'd6:    hdr_byte = 8'h7D;
      3'd7:    hdr_byte = 8'h74;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  // Loss fires once, the first clock no valid half-period can still end.
  assign tap_edge  = tap_sync[2] ^ tap_sync[1];
  assign half_ok   = tap_edge && (hcnt >= HALF_MIN) && (hcnt <= HALF_MAX);
  assign is_long   = (hcnt >= HALF_THR);
  assign lost      = (hcnt == HALF_MAX + 16'd1);
  assign short_cyc = half_ok && have_half && !half_long && !is_long;
  assign long_cyc  = half_ok && have_half && half_long && is_long;
  assign mixed     = half_ok && have_half && (half_long != is_long);
  assign bit_done  = long_cyc || (short_cyc && one_half);

  assign fill  = wptr - rptr;
  assign full  = (fill == FIFO_DEPTH[AW:0]);
  assign empty = (wptr == rptr);
  assign pop   = !empty && ((wr_req && bus.sdram_ready) || addr_full);

  // Synchroniser and half-period counter; glitch edges leave the count running.
  always_ff @(posedge clk) begin
    if (reset) begin
      tap_sync <= 3'b000;
      hcnt     <= 16'd0;
    end else begin
      tap_sync <= {tap_sync[1:0], tap_i};
      if (tap_edge && (hcnt >= HALF_MIN)) hcnt <= 16'd0;
      else if (hcnt != 16'hFFFF)          hcnt <= hcnt + 16'd1;
    end
  end

  // Pair half-periods into cycles; on a mixed pair the newer half restarts the pairing.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE) || lost) begin
      have_half <= 1'b0;
      half_long <= 1'b0;
    end else if (half_ok) begin
      if (!have_half) begin
        have_half <= 1'b1;
        half_long <= is_long;
      end else if (half_long == is_long) begin
        have_half <= 1'b0;
      end else begin
        half_long <= is_long;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || rewind) state <= IDLE;
    else                 state <= next_state;
  end

  // Next state plus FIFO push requests.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_data  = 8'h00;
    err        = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (record) next_state = LEADER;
        else        next_state = IDLE;
      end
      LEADER: begin
        if (short_cyc && (lcnt == LEADER_MIN - 10'd1)) next_state = HDR;
        else                                           next_state = LEADER;
      end
      HDR: begin
        push_data = hdr_byte(hidx);
        if (!full) begin
          push = 1'b1;
          if (hidx == 3'd7) next_state = SYNC;
          else              next_state = HDR;
        end else begin
          next_state = HDR;
        end
      end
      SYNC: begin
        if (lost)          next_state = LEADER;
        else if (long_cyc) next_state = DATA;
        else               next_state = SYNC;
      end
      DATA: begin
        if (lost || mixed || (long_cyc && one_half)) begin
          err        = 1'b1;
          next_state = LEADER;
        end else if (bit_done && (bcnt == 3'd7)) begin
          push_data  = {shreg, short_cyc};
          push       = !full;
          drop       = full;
          next_state = SYNC;
        end else begin
          next_state = DATA;
        end
      end
      default: next_state = IDLE;
    endcase
    if (!record) next_state = IDLE;
    else         next_state = next_state;
  end

  // Leader length, header index and bit assembly; each clears outside its own state.
  always_ff @(posedge clk) begin
    if (reset || (state != LEADER) || long_cyc || lost || mixed) lcnt <= 10'd0;
    else if (short_cyc)                                          lcnt <= lcnt + 10'd1;

    if (reset || (state != HDR)) hidx <= 3'd0;
    else if (!full)              hidx <= hidx + 3'd1;

    if (reset || (state != DATA)) begin
      bcnt     <= 3'd0;
      one_half <= 1'b0;
      shreg    <= 7'd0;
    end else if (long_cyc) begin
      shreg <= {shreg[5:0], 1'b0};
      bcnt  <= bcnt + 3'd1;
    end else if (short_cyc) begin
      if (one_half) begin
        shreg    <= {shreg[5:0], 1'b1};
        bcnt     <= bcnt + 3'd1;
        one_half <= 1'b0;
      end else begin
        one_half <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[AW-1:0]] <= push_data;
  end

  // FIFO pointers, SDRAM request/handshake and sticky status.
  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      wptr         <= '0;
      rptr         <= '0;
      wr_req       <= 1'b0;
      wr_addr      <= 21'd0;
      wr_data      <= 8'h00;
      addr_full    <= 1'b0;
      overflow     <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (wr_req) begin
        if (bus.sdram_ready) begin
          wr_req <= 1'b0;
          if (wr_addr == 21'h1FFFFF) begin
            addr_full <= 1'b1;
            overflow  <= 1'b1;
          end else begin
            wr_addr <= wr_addr + 21'd1;
          end
        end
      end else if (!empty && bus.sdram_available && !addr_full) begin
        wr_req  <= 1'b1;
        wr_data <= fifo_mem[rptr[AW-1:0]];
      end
      if (drop) overflow     <= 1'b1;
      if (err)  decode_error <= 1'b1;
    end
  end

  assign bus.sdram_wr   = wr_req;
  assign bus.sdram_addr = wr_addr;
  assign bus.sdram_data = wr_data;
  assign length         = wr_addr;
  assign status         = {overflow, decode_error, (state == SYNC) || (state == DATA)};
endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder with scaled-down timing parameters and a
// small SDRAM responder that logs every accepted write.
`timescale 1ns/1ps
module tb_cassette_recorder;
  localparam int SH = 44;
  localparam int LH = 88;

  logic        clk = 1'b0;
  logic        reset, record, rewind, tap;
  logic [20:0] length;
  logic [2:0]  status;
  logic        hold;
  int          wait_cnt;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [20:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic [7:0]  hdr_exp [8] = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};

  cassette_recorder_if bus();

  cassette_recorder #(
    .HALF_MIN(16'd20), .HALF_THR(16'd70), .HALF_MAX(16'd120),
    .LEADER_MIN(10'd8), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .record(record), .rewind(rewind), .tap_i(tap),
    .bus(bus), .length(length), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half(input int n);
    repeat (n) @(negedge clk);
    tap = ~tap;
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      half(SH); half(SH); half(SH); half(SH);
    end else begin
      half(LH); half(LH);
    end
  endtask

  task automatic send_leader();
    for (int i = 0; i < 24; i++) half(SH);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_rewind();
    @(negedge clk);
    rewind = 1'b1;
    repeat (2) @(negedge clk);
    rewind = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  // SDRAM model: accept a pending write two clocks after it appears unless held.
  initial begin
    bus.sdram_ready = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.sdram_ready) begin
        bus.sdram_ready = 1'b0;
      end else if (bus.sdram_wr && !hold) begin
        if (wait_cnt >= 2) begin
          bus.sdram_ready = 1'b1;
          wait_cnt = 0;
          log_addr.push_back(bus.sdram_addr);
          log_data.push_back(bus.sdram_data);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; record = 1'b0; rewind = 1'b0; tap = 1'b0; hold = 1'b0;
    bus.sdram_available = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_wr", {31'd0, bus.sdram_wr}, 32'd0);
    chk("rst_addr", {11'd0, bus.sdram_addr}, 32'd0);
    chk("rst_len", {11'd0, length}, 32'd0);
    chk("rst_status", {29'd0, status}, 32'd0);
    reset = 1'b0;
    record = 1'b1;

    // Leader then header written to 0..7.
    send_leader();
    chk("ldr_len", {11'd0, length}, 32'd8);
    chk("ldr_status", {29'd0, status}, 32'd1);
    chk("ldr_count", log_data.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hdr_data%0d", i), {24'd0, log_data[i]}, {24'd0, hdr_exp[i]});
      chk($sformatf("hdr_addr%0d", i), {11'd0, log_addr[i]}, i);
    end

    // A5 with a short glitch pulse early in the first '0' data bit.
    send_bit(1'b0);
    send_bit(1'b1);
    half(5); half(5); half(LH - 10); half(LH);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (20) @(negedge clk);
    chk("byte_count", log_data.size(), 32'd9);
    chk("byte_data", {24'd0, log_data[8]}, 32'hA5);
    chk("byte_addr", {11'd0, log_addr[8]}, 32'd8);
    chk("byte_len", {11'd0, length}, 32'd9);
    chk("byte_status", {29'd0, status}, 32'd1);

    // Carrier lost after four data bits.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (300) @(negedge clk);
    chk("loss_count", log_data.size(), 32'd9);
    chk("loss_len", {11'd0, length}, 32'd9);
    chk("loss_status", {29'd0, status}, 32'd2);

    // Backpressure: header fills the FIFO, the data byte overflows.
    bus.sdram_available = 1'b0;
    do_rewind();
    chk("rew_status", {29'd0, status}, 32'd0);
    send_leader();
    send_byte(8'h3C);
    repeat (20) @(negedge clk);
    chk("bp_status", {29'd0, status}, 32'd5);
    chk("bp_len", {11'd0, length}, 32'd0);
    chk("bp_wr", {31'd0, bus.sdram_wr}, 32'd0);
    bus.sdram_available = 1'b1;
    repeat (60) @(negedge clk);
    chk("bp_len_after", {11'd0, length}, 32'd8);
    chk("bp_ovf", {31'd0, status[2]}, 32'd1);
    chk("bp_count", log_data.size(), 32'd8);
    chk("bp_first", {24'd0, log_data[0]}, 32'h1F);
    chk("bp_last", {24'd0, log_data[7]}, 32'h74);

    // Held request stays stable, survives availability loss, and rewind drops it.
    hold = 1'b1;
    do_rewind();
    send_leader();
    chk("hs_wr", {31'd0, bus.sdram_wr}, 32'd1);
    chk("hs_addr", {11'd0, bus.sdram_addr}, 32'd0);
    chk("hs_data", {24'd0, bus.sdram_data}, 32'h1F);
    bus.sdram_available = 1'b0;
    repeat (5) @(negedge clk);
    chk("hs_wr_held", {31'd0, bus.sdram_wr}, 32'd1);
    chk("hs_addr_held", {11'd0, bus.sdram_addr}, 32'd0);
    chk("hs_data_held", {24'd0, bus.sdram_data}, 32'h1F);
    chk("hs_len_held", {11'd0, length}, 32'd0);
    rewind = 1'b1;
    @(negedge clk);
    chk("hs_rew_wr", {31'd0, bus.sdram_wr}, 32'd0);
    chk("hs_rew_len", {11'd0, length}, 32'd0);
    chk("hs_rew_status", {29'd0, status}, 32'd0);
    rewind = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
